// File: rtl/lsu_pkg.sv
// Shared memOp encodings, FSM states and fault cause codes for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;
  localparam logic [2:0] M_LHU = 3'd5;
  localparam logic [2:0] M_SB  = M_LB;
  localparam logic [2:0] M_SH  = M_LH;
  localparam logic [2:0] M_SW  = M_LW;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StWr     = 2'd2,
    StResp   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    CauseNone       = 2'd0,
    CauseMisaligned = 2'd1,
    CauseIllegal    = 2'd2
  } lsu_cause_e;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality and alignment check of an incoming memory request.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       write,
  input  logic [1:0] addr,
  output logic       fault,
  output logic [1:0] cause
);

  logic illegal;
  logic misaligned;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (op)
      3'd3, 3'd6, 3'd7: illegal = 1'b1;
      M_LBU, M_LHU:     illegal = write;
      default:          illegal = 1'b0;
    endcase
    case (op)
      M_LH, M_LHU: misaligned = addr[0];
      M_LW:        misaligned = |addr;
      default:     misaligned = 1'b0;
    endcase
    fault = illegal | misaligned;
    // Illegal op takes priority when both conditions hold.
    if (illegal) begin
      cause = CauseIllegal;
    end else if (misaligned) begin
      cause = CauseMisaligned;
    end else begin
      cause = CauseNone;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: validates one request at a time, strobes the data memory and
// returns load data or a fault over a valid/ready response channel.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [2:0]        reqOp,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspRdata,
  output logic              rspFault,
  output logic [1:0]        rspCause,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic [2:0]        memOp,
  output logic              memWe,
  output logic              memRe,
  input  logic [DATA_W-1:0] memDout
);

  localparam logic [3:0] LatInit = 4'(RD_LAT);

  lsu_state_e        state_q, state_d;
  logic              ready_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        op_q;
  logic              fault_q;
  logic [1:0]        cause_q;
  logic              chk_fault;
  logic [1:0]        chk_cause;
  logic              accept;

  lsu_align_check u_align_check (
    .op    (reqOp),
    .write (reqWrite),
    .addr  (reqAddr[1:0]),
    .fault (chk_fault),
    .cause (chk_cause)
  );

  // ready_q keeps reqReady low until the first edge after reset release.
  assign reqReady = ready_q & (state_q == StIdle);
  assign accept   = reqValid & reqReady;

  assign memAddr  = addr_q;
  assign memDin   = wdata_q;
  assign memOp    = op_q;
  assign rspRdata = rdata_q;
  assign rspFault = fault_q;
  assign rspCause = cause_q;

  always_comb begin
    state_d  = state_q;
    memRe    = 1'b0;
    memWe    = 1'b0;
    rspValid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (chk_fault) begin
            state_d = StResp;
          end else if (reqWrite) begin
            state_d = StWr;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        memRe = (cnt_q == LatInit);
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end
      end
      StWr: begin
        memWe   = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rspValid = 1'b1;
        if (rspReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= 3'd0;
      fault_q <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (accept) begin
        addr_q  <= reqAddr;
        wdata_q <= reqWdata;
        op_q    <= reqOp;
        rdata_q <= '0;
        fault_q <= chk_fault;
        cause_q <= chk_cause;
        cnt_q   <= LatInit;
      end else if (state_q == StRdWait) begin
        if (cnt_q == 4'd0) begin
          rdata_q <= memDout;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

endmodule
